// File: rtl/regbank_writer.sv
// 32-entry register bank write side: one-hot decoded write enables, a
// hardwired-zero entry, and last-write / write-count status.

module regbank_cell #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  data_q <= '0;
    else if (en) data_q <= d;
  end

  assign q = data_q;
endmodule

module regbank_writer #(
  parameter int WIDTH    = 64,
  parameter int ZERO_REG = 31
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   RegWrite,
  input  logic [4:0]             WriteRegister,
  input  logic [WIDTH-1:0]       WriteData,
  output logic [31:0][WIDTH-1:0] regs,
  output logic [4:0]             LastReg,
  output logic                   LastValid,
  output logic [15:0]            WriteCount
);
  logic [31:0] we;
  logic        accept;

  logic [4:0]  last_reg_q, last_reg_d;
  logic        last_vld_q, last_vld_d;
  logic [15:0] wcnt_q,     wcnt_d;

  genvar i;
  generate
    for (i = 0; i < 32; i++) begin : g_lane
      if (i == ZERO_REG) begin : g_zero
        // Zero entry has no storage; its enable is forced low so it never
        // counts as an accepted write.
        assign we[i]   = 1'b0;
        assign regs[i] = '0;
      end else begin : g_reg
        assign we[i] = RegWrite && (WriteRegister == 5'(i));
        regbank_cell #(.WIDTH(WIDTH)) u_cell (
          .clk   (clk),
          .reset (reset),
          .en    (we[i]),
          .d     (WriteData),
          .q     (regs[i])
        );
      end
    end
  endgenerate

  assign accept = |we;

  always_comb begin
    last_reg_d = last_reg_q;
    last_vld_d = 1'b0;
    wcnt_d     = wcnt_q;
    if (accept) begin
      last_reg_d = WriteRegister;
      last_vld_d = 1'b1;
      wcnt_d     = wcnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_reg_q <= '0;
      last_vld_q <= 1'b0;
      wcnt_q     <= '0;
    end else begin
      last_reg_q <= last_reg_d;
      last_vld_q <= last_vld_d;
      wcnt_q     <= wcnt_d;
    end
  end

  assign LastReg    = last_reg_q;
  assign LastValid  = last_vld_q;
  assign WriteCount = wcnt_q;
endmodule
